// File: rtl/screen_flag_conditioner.sv
// -----------------------------------------------------------------------------
// screen_flag_conditioner
//
// Purpose:
//   Conditions the raw, asynchronous screen/frame-ready level from the video
//   side into a clean level for the screen PIO in_port. The raw level is
//   synchronized and then glitch-filtered. Each accepted rising edge:
//     - emits a one-cycle frame_pulse, and
//     - stretches out_port high for at least HOLD_CYCLES clocks.
//   out_port then stays high for as long as the filtered level remains high.
//
// Ports:
//   clk          in   1      system clock
//   reset_n      in   1      asynchronous active-low reset
//   screen_raw   in   1      raw screen-ready level, asynchronous to clk
//   out_port     out  1      conditioned level for the PIO in_port (registered)
//   frame_pulse  out  1      one-cycle pulse per accepted rising edge
//   frame_count  out  CNT_W  accepted frame events, wraps at 2^CNT_W
//                            (present only when SCREEN_FRAME_CNT_EN is defined)
//
// Configuration macro:
//   SCREEN_FRAME_CNT_EN  adds the frame_count port and its counter.
//
// Latency: a clean raw 0->1 reaches out_port and frame_pulse after
//   SYNC_STAGES + FILTER_CYCLES + 1 rising clock edges.
// -----------------------------------------------------------------------------
module screen_flag_conditioner #(
  parameter int SYNC_STAGES   = 2,      // >= 2
  parameter int FILTER_CYCLES = 4,      // >= 1
  parameter int HOLD_CYCLES   = 50000,  // >= 1
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             screen_raw,
  output logic             out_port,
  output logic             frame_pulse
`ifdef SCREEN_FRAME_CNT_EN
  ,
  output logic [CNT_W-1:0] frame_count
`endif
);

  localparam int FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer chain
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], screen_raw};
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Glitch filter: a new level must disagree with filt for FILTER_CYCLES
  // consecutive cycles before it is accepted. Any agreement restarts the count.
  // ---------------------------------------------------------------------------
  logic           filt;
  logic           filt_d;
  logic [FCW-1:0] filt_cnt;
  logic           rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt     <= 1'b0;
      filt_cnt <= '0;
      filt_d   <= 1'b0;
    end else begin
      filt_d <= filt;
      if (sync_q == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt     <= sync_q;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign rise = filt & ~filt_d;

  // ---------------------------------------------------------------------------
  // Hold FSM. out_port is high in HOLD and WAIT_LOW. A rise always wins over
  // hold expiry, so a retrigger on the last hold cycle keeps out_port high.
  // ---------------------------------------------------------------------------
  state_t         state;
  logic [HCW-1:0] hold_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      out_port    <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= rise;
      case (state)
        IDLE: begin
          if (rise) begin
            hold_cnt <= HOLD_LOAD;
            state    <= HOLD;
            out_port <= 1'b1;
          end
        end
        HOLD: begin
          if (rise) begin
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt == '0) begin
            // Expired: keep the level up while the filtered input is still high
            if (filt) begin
              state <= WAIT_LOW;
            end else begin
              state    <= IDLE;
              out_port <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        WAIT_LOW: begin
          if (rise) begin
            hold_cnt <= HOLD_LOAD;
            state    <= HOLD;
          end else if (!filt) begin
            state    <= IDLE;
            out_port <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          out_port <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCREEN_FRAME_CNT_EN
  // Counts on the same edge that raises frame_pulse; wraps freely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (rise) begin
      frame_count <= frame_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_screen_flag_conditioner.sv
// -----------------------------------------------------------------------------
// tb_screen_flag_conditioner
//
// Purpose:
//   Directed and randomized stimulus for screen_flag_conditioner with
//   HOLD_CYCLES=8, CNT_W=4. A behavioural reference model expresses the
//   behaviour as rules over sample history:
//     - synced level = raw delayed by SYNC_STAGES-1 samples,
//     - filtered level flips once the last FILTER_CYCLES synced samples all
//       disagree with it,
//     - pulse = filtered level rose one cycle earlier,
//     - out = (a pulse within the last HOLD cycles) or (out was high and the
//       filtered level is still high).
//   Directed checks compare against constants for glitch rejection, short
//   and long events, retrigger, reset mid-hold and counter wrap.
// Ports: none (top-level bench).
// Optional macro: SCREEN_FRAME_CNT_EN enables frame_count checks.
// -----------------------------------------------------------------------------
module tb_screen_flag_conditioner;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int HOLD = 8;
  localparam int CW   = 4;
  localparam int AGE_NONE = 1000000;

  logic clk        = 1'b0;
  logic reset_n    = 1'b1;
  logic screen_raw = 1'b0;
  logic out_port;
  logic frame_pulse;
`ifdef SCREEN_FRAME_CNT_EN
  logic [CW-1:0] frame_count;
`endif

  screen_flag_conditioner #(
    .SYNC_STAGES  (SYNC),
    .FILTER_CYCLES(FILT),
    .HOLD_CYCLES  (HOLD),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .screen_raw (screen_raw),
    .out_port   (out_port),
    .frame_pulse(frame_pulse)
`ifdef SCREEN_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_sync [SYNC];
  bit m_hist [FILT];
  bit m_filt, m_filt_prev, m_out, m_pulse;
  int m_age;
  int m_count;

  // Observation statistics
  int   cyc = 0;
  int   base = 0;
  int   n_pulse, n_outhi, n_drops, first_rise, last_fall;
  logic prev_out = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    for (int i = 0; i < FILT; i++) m_hist[i] = 1'b0;
    m_filt = 1'b0;
    m_filt_prev = 1'b0;
    m_out = 1'b0;
    m_pulse = 1'b0;
    m_age = AGE_NONE;
    m_count = 0;
  endtask

  task automatic model_step(input bit raw);
    bit pulse_new, all_diff, filt_new, out_new;
    pulse_new = m_filt && !m_filt_prev;
    all_diff = 1'b1;
    for (int i = 0; i < FILT; i++) if (m_hist[i] == m_filt) all_diff = 1'b0;
    filt_new = all_diff ? !m_filt : m_filt;
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = raw;
    for (int i = FILT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_sync[SYNC-1];
    if (pulse_new) m_age = 0;
    else if (m_age < AGE_NONE) m_age++;
    out_new = (m_age < HOLD) || (m_out && m_filt);
    m_filt_prev = m_filt;
    m_filt = filt_new;
    m_out = out_new;
    m_pulse = pulse_new;
    m_count = (m_count + (pulse_new ? 1 : 0)) % (1 << CW);
  endtask

  task automatic clear_stats();
    n_pulse = 0;
    n_outhi = 0;
    n_drops = 0;
    first_rise = -1;
    last_fall = -1;
  endtask

  task automatic tick(input logic raw);
    screen_raw = raw;
    @(posedge clk);
    cyc++;
    if (!reset_n) model_reset();
    else model_step(raw);
    #1;
    chk("out_port", 32'(out_port), 32'(m_out));
    chk("frame_pulse", 32'(frame_pulse), 32'(m_pulse));
`ifdef SCREEN_FRAME_CNT_EN
    chk("frame_count", 32'(frame_count), 32'(m_count));
`endif
    if (frame_pulse === 1'b1) n_pulse++;
    if (out_port === 1'b1) n_outhi++;
    if (prev_out === 1'b1 && out_port === 1'b0) begin
      n_drops++;
      last_fall = cyc;
    end
    if (prev_out === 1'b0 && out_port === 1'b1 && first_rise < 0) first_rise = cyc;
    prev_out = out_port;
  endtask

  task automatic run(input logic lvl, input int n);
    repeat (n) tick(lvl);
  endtask

  initial begin
    clear_stats();
    model_reset();

    // 1: reset held with raw high, then release
    reset_n = 1'b0;
    screen_raw = 1'b1;
    #1;
    run(1'b1, 3);
    chk("reset_out", 32'(out_port), 32'd0);
    chk("reset_pulse", 32'(frame_pulse), 32'd0);
`ifdef SCREEN_FRAME_CNT_EN
    chk("reset_count", 32'(frame_count), 32'd0);
`endif
    reset_n = 1'b1;
    clear_stats();
    base = cyc;
    run(1'b1, 10);
    chk("rise_edge", 32'(first_rise - base), 32'd7);
    run(1'b0, 20);

    // 2: 3-cycle glitch is dropped
    clear_stats();
    run(1'b1, 3);
    run(1'b0, 15);
    chk("glitch_pulses", 32'(n_pulse), 32'd0);
    chk("glitch_outhi", 32'(n_outhi), 32'd0);

    // 3: short event stretched to HOLD cycles
    clear_stats();
    run(1'b1, 5);
    run(1'b0, 20);
    chk("short_pulses", 32'(n_pulse), 32'd1);
    chk("short_outhi", 32'(n_outhi), 32'd8);

    // 4: long event follows the input, falls 7 edges after raw falls
    clear_stats();
    run(1'b1, 30);
    base = cyc;
    run(1'b0, 20);
    chk("long_pulses", 32'(n_pulse), 32'd1);
    chk("long_outhi", 32'(n_outhi), 32'd30);
    chk("long_fall_edge", 32'(last_fall - base), 32'd7);

    // 5: second accepted rise lands on the last hold cycle -> continuous high
    clear_stats();
    run(1'b1, 4);
    run(1'b0, 4);
    run(1'b1, 5);
    run(1'b0, 25);
    chk("retrig_pulses", 32'(n_pulse), 32'd2);
    chk("retrig_outhi", 32'(n_outhi), 32'd16);
    chk("retrig_drops", 32'(n_drops), 32'd1);

    // 6: reset mid-HOLD (hold_cnt=4 after 10 edges), then counter wrap
    clear_stats();
    run(1'b1, 5);
    run(1'b0, 5);
    chk("midhold_out", 32'(out_port), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midhold_rst_out", 32'(out_port), 32'd0);
    chk("midhold_rst_pulse", 32'(frame_pulse), 32'd0);
    prev_out = out_port;
    run(1'b0, 2);
    reset_n = 1'b1;
    run(1'b0, 5);
    clear_stats();
    repeat (17) begin
      run(1'b1, 5);
      run(1'b0, 12);
    end
    chk("wrap_pulses", 32'(n_pulse), 32'd17);
`ifdef SCREEN_FRAME_CNT_EN
    chk("wrap_count", 32'(frame_count), 32'd1);
`endif

    // Randomized runs against the reference model, with one async reset
    for (int it = 0; it < 80; it++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      if (it == 40) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rand_rst_out", 32'(out_port), 32'd0);
        prev_out = out_port;
        tick(lvl);
        reset_n = 1'b1;
      end
      run(lvl, len);
    end
    run(1'b0, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
